// File: rtl/seq_cmd_handler.sv
// Command front-end for the sequence generator bank: collects one channel's
// configuration from the host byte stream, validates it and strobes it into the bank.
module seq_cmd_handler #(
    parameter logic [7:0] CMD_CODE     = 8'hF0,
    parameter int         NUM_CHANNELS = 8,
    parameter int         PAYLOAD_LEN  = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_type_in,
    input  logic [15:0] cmd_length_in,
    input  logic        cmd_start,
    input  logic [7:0]  cmd_data_in,
    input  logic        cmd_data_valid,
    input  logic        cmd_done,
    output logic        cmd_ready,
    output logic        cmd_ack,
    output logic [1:0]  err_code,
    output logic [2:0]  config_ch_index_out,
    output logic        config_enable_out,
    output logic [15:0] config_freq_div_out,
    output logic [6:0]  config_seq_len_out,
    output logic [63:0] config_seq_data_out,
    output logic        config_update_strobe
);

    localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_LENGTH  = 2'd1;
    localparam logic [1:0] ERR_SHORT   = 2'd2;
    localparam logic [1:0] ERR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DRAIN,
        CHECK,
        APPLY
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;

    logic [7:0]         sh_ch_q, sh_ch_d;
    logic               sh_en_q, sh_en_d;
    logic [15:0]        sh_div_q, sh_div_d;
    logic [7:0]         sh_len_q, sh_len_d;
    logic [63:0]        sh_data_q, sh_data_d;

    logic               cmd_ready_q, cmd_ready_d;
    logic               cmd_ack_q, cmd_ack_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [2:0]         cfg_ch_q, cfg_ch_d;
    logic               cfg_en_q, cfg_en_d;
    logic [15:0]        cfg_div_q, cfg_div_d;
    logic [6:0]         cfg_len_q, cfg_len_d;
    logic [63:0]        cfg_data_q, cfg_data_d;
    logic               strobe_q, strobe_d;

    logic               xfer;
    logic               start_hit;
    logic               fields_ok;

    assign xfer      = cmd_data_valid && cmd_ready_q;
    assign start_hit = cmd_start && (cmd_type_in == CMD_CODE);

    // Channel byte compared whole, so any set bit in [7:3] also rejects it.
    assign fields_ok = (sh_ch_q < 8'(NUM_CHANNELS))
                    && (sh_len_q != 8'd0)
                    && (sh_len_q <= 8'd64)
                    && !(sh_en_q && (sh_div_q == 16'd0));

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        sh_ch_d     = sh_ch_q;
        sh_en_d     = sh_en_q;
        sh_div_d    = sh_div_q;
        sh_len_d    = sh_len_q;
        sh_data_d   = sh_data_q;
        cmd_ready_d = cmd_ready_q;
        cmd_ack_d   = 1'b0;
        err_code_d  = err_code_q;
        cfg_ch_d    = cfg_ch_q;
        cfg_en_d    = cfg_en_q;
        cfg_div_d   = cfg_div_q;
        cfg_len_d   = cfg_len_q;
        cfg_data_d  = cfg_data_q;
        strobe_d    = 1'b0;

        // A matching start while idle or mid-frame (re)opens a frame without acking the old one.
        if (start_hit && (state_q == IDLE || state_q == RECV || state_q == DRAIN)) begin
            err_code_d  = ERR_OK;
            byte_cnt_d  = '0;
            cmd_ready_d = 1'b1;
            if (cmd_length_in == 16'(PAYLOAD_LEN)) begin
                state_d = RECV;
            end else begin
                err_code_d = ERR_LENGTH;
                state_d    = DRAIN;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_d = 1'b1;
                end

                RECV: begin
                    if (xfer) begin
                        case (byte_cnt_q)
                            CNT_W'(0): sh_ch_d  = cmd_data_in;
                            CNT_W'(1): sh_en_d  = cmd_data_in[0];
                            CNT_W'(2),
                            CNT_W'(3): sh_div_d = {sh_div_q[7:0], cmd_data_in};
                            CNT_W'(4): sh_len_d = cmd_data_in;
                            default:   sh_data_d = {sh_data_q[55:0], cmd_data_in};
                        endcase
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                    if (xfer && byte_cnt_q == LAST_IDX) begin
                        cmd_ready_d = 1'b0;
                        state_d     = CHECK;
                    end else if (cmd_done) begin
                        err_code_d = ERR_SHORT;
                        cmd_ack_d  = 1'b1;
                        state_d    = IDLE;
                    end
                end

                DRAIN: begin
                    if (cmd_done) begin
                        cmd_ack_d = 1'b1;
                        state_d   = IDLE;
                    end
                end

                // Outputs are loaded only once the fields pass, so a rejected
                // frame leaves the bank-facing configuration untouched.
                CHECK: begin
                    if (fields_ok) begin
                        cfg_ch_d   = sh_ch_q[2:0];
                        cfg_en_d   = sh_en_q;
                        cfg_div_d  = sh_div_q;
                        cfg_len_d  = sh_len_q[6:0];
                        cfg_data_d = sh_data_q;
                        strobe_d   = 1'b1;
                        cmd_ack_d  = 1'b1;
                        err_code_d = ERR_OK;
                        state_d    = APPLY;
                    end else begin
                        err_code_d  = ERR_INVALID;
                        cmd_ack_d   = 1'b1;
                        cmd_ready_d = 1'b1;
                        state_d     = IDLE;
                    end
                end

                APPLY: begin
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end

                default: begin
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            sh_ch_q     <= '0;
            sh_en_q     <= 1'b0;
            sh_div_q    <= '0;
            sh_len_q    <= '0;
            sh_data_q   <= '0;
            cmd_ready_q <= 1'b1;
            cmd_ack_q   <= 1'b0;
            err_code_q  <= ERR_OK;
            cfg_ch_q    <= '0;
            cfg_en_q    <= 1'b0;
            cfg_div_q   <= '0;
            cfg_len_q   <= '0;
            cfg_data_q  <= '0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            sh_ch_q     <= sh_ch_d;
            sh_en_q     <= sh_en_d;
            sh_div_q    <= sh_div_d;
            sh_len_q    <= sh_len_d;
            sh_data_q   <= sh_data_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_ack_q   <= cmd_ack_d;
            err_code_q  <= err_code_d;
            cfg_ch_q    <= cfg_ch_d;
            cfg_en_q    <= cfg_en_d;
            cfg_div_q   <= cfg_div_d;
            cfg_len_q   <= cfg_len_d;
            cfg_data_q  <= cfg_data_d;
            strobe_q    <= strobe_d;
        end
    end

    assign cmd_ready            = cmd_ready_q;
    assign cmd_ack              = cmd_ack_q;
    assign err_code             = err_code_q;
    assign config_ch_index_out  = cfg_ch_q;
    assign config_enable_out    = cfg_en_q;
    assign config_freq_div_out  = cfg_div_q;
    assign config_seq_len_out   = cfg_len_q;
    assign config_seq_data_out  = cfg_data_q;
    assign config_update_strobe = strobe_q;

endmodule
